// File: rtl/memory_cycle.sv
// MEM pipeline stage: branch/jump resolution, ready-handshaked data-memory access
// with lane alignment and load extension, and the MEM/WB pipeline register.
module memory_cycle #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        i_mem_clk,
    input  logic        i_mem_reset,
    input  logic [31:0] i_mem_pc,
    input  logic [31:0] i_mem_inst,
    input  logic [31:0] i_mem_alu_data,
    input  logic [31:0] i_mem_rs2_data,
    input  logic        i_mem_br_equal,
    input  logic        i_mem_br_less,
    input  logic        i_mem_lsu_wren,
    input  logic [2:0]  i_mem_slt_sl,
    input  logic [1:0]  i_mem_wb_sel,
    input  logic        i_mem_rd_wren,
    input  logic        i_dmem_ready,
    input  logic [31:0] i_dmem_rdata,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [31:0] o_dmem_addr,
    output logic [31:0] o_dmem_wdata,
    output logic [3:0]  o_dmem_bmask,
    output logic        o_mem_stall,
    output logic        o_mem_flush,
    output logic [31:0] o_mem_pc_target,
    output logic        o_mem_misaligned,
    output logic        o_mem_bus_err,
    output logic [31:0] o_mem_fwd_alu_data,
    output logic [31:0] o_mem_alu_data_wb,
    output logic [31:0] o_mem_ld_data_wb,
    output logic [31:0] o_mem_pc4_wb,
    output logic [1:0]  o_mem_wb_sel_wb,
    output logic        o_mem_rd_wren_wb,
    output logic [31:0] o_mem_inst_wb
);

    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [31:0] alu_data_q, alu_data_d;
    logic [31:0] ld_data_q,  ld_data_d;
    logic [31:0] pc4_q,      pc4_d;
    logic [1:0]  wb_sel_q,   wb_sel_d;
    logic        rd_wren_q,  rd_wren_d;
    logic [31:0] inst_q,     inst_d;

    logic [1:0]  off;
    logic [1:0]  size;
    logic        is_unsigned;
    logic        access;
    logic        misaligned;
    logic        aligned_access;
    logic        timeout;
    logic        taken;

    logic        req_c;
    logic        stall_c;
    logic        flush_c;
    logic        misaligned_c;
    logic        bus_err_c;

    logic [3:0]  lane_mask;
    logic [31:0] lane_wdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    // Access classification and alignment check
    always_comb begin
        off            = i_mem_alu_data[1:0];
        size           = i_mem_slt_sl[1:0];
        is_unsigned    = i_mem_slt_sl[2];
        access         = i_mem_lsu_wren | (i_mem_wb_sel == 2'b01);
        misaligned     = 1'b0;
        if (size == 2'b01) begin
            misaligned = off[0];
        end else if (size[1]) begin
            misaligned = (off != 2'b00);
        end
        misaligned     = misaligned & access;
        aligned_access = access & ~misaligned;
        timeout        = (state_q == S_WAIT) && !i_dmem_ready
                         && (cnt_q == CNT_W'(MAX_WAIT));
    end

    // Store lane placement
    always_comb begin
        lane_mask  = 4'b1111;
        lane_wdata = i_mem_rs2_data;
        case (size)
            2'b00: begin
                lane_mask  = 4'b0001 << off;
                lane_wdata = {4{i_mem_rs2_data[7:0]}};
            end
            2'b01: begin
                lane_mask  = 4'b0011 << off;
                lane_wdata = {2{i_mem_rs2_data[15:0]}};
            end
            default: begin
                lane_mask  = 4'b1111;
                lane_wdata = i_mem_rs2_data;
            end
        endcase
    end

    // Load lane extraction and extension
    always_comb begin
        ld_byte = 8'(i_dmem_rdata >> {off, 3'b000});
        ld_half = off[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];
        case (size)
            2'b00:   ld_ext = is_unsigned ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            2'b01:   ld_ext = is_unsigned ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ld_ext = i_dmem_rdata;
        endcase
    end

    // Branch and jump resolution
    always_comb begin
        taken = 1'b0;
        if (i_mem_inst[6:0] == OP_JAL || i_mem_inst[6:0] == OP_JALR) begin
            taken = 1'b1;
        end else if (i_mem_inst[6:0] == OP_BRANCH) begin
            case (i_mem_inst[14:12])
                3'b000:         taken = i_mem_br_equal;
                3'b001:         taken = ~i_mem_br_equal;
                3'b100, 3'b110: taken = i_mem_br_less;
                3'b101, 3'b111: taken = ~i_mem_br_less;
                default:        taken = 1'b0;
            endcase
        end
    end

    // FSM state and wait counter register
    always_ff @(posedge i_mem_clk) begin
        if (i_mem_reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (aligned_access && !i_dmem_ready) begin
                    state_d = S_WAIT;
                    cnt_d   = CNT_W'(1);
                end
            end
            S_WAIT: begin
                if (i_dmem_ready || timeout) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM outputs; upstream is frozen during WAIT so the live inputs hold the request stable
    always_comb begin
        req_c        = 1'b0;
        stall_c      = 1'b0;
        bus_err_c    = 1'b0;
        misaligned_c = 1'b0;
        flush_c      = 1'b0;
        if (!i_mem_reset) begin
            case (state_q)
                S_IDLE: begin
                    req_c        = aligned_access;
                    stall_c      = aligned_access & ~i_dmem_ready;
                    misaligned_c = misaligned;
                end
                S_WAIT: begin
                    req_c        = aligned_access & ~timeout;
                    stall_c      = aligned_access & ~i_dmem_ready & ~timeout;
                    bus_err_c    = timeout;
                end
                default: begin
                    req_c = 1'b0;
                end
            endcase
            flush_c = taken & ~stall_c;
        end
    end

    // MEM/WB next values: bubble while stalled or aborted, suppressed write on misalignment
    always_comb begin
        alu_data_d = i_mem_alu_data;
        ld_data_d  = ld_ext;
        pc4_d      = i_mem_pc + 32'd4;
        wb_sel_d   = i_mem_wb_sel;
        rd_wren_d  = i_mem_rd_wren;
        inst_d     = i_mem_inst;
        if (stall_c || bus_err_c) begin
            wb_sel_d  = 2'b00;
            rd_wren_d = 1'b0;
            inst_d    = 32'd0;
        end else if (misaligned_c) begin
            rd_wren_d = 1'b0;
        end
    end

    always_ff @(posedge i_mem_clk) begin
        if (i_mem_reset) begin
            alu_data_q <= '0;
            ld_data_q  <= '0;
            pc4_q      <= '0;
            wb_sel_q   <= '0;
            rd_wren_q  <= 1'b0;
            inst_q     <= '0;
        end else begin
            alu_data_q <= alu_data_d;
            ld_data_q  <= ld_data_d;
            pc4_q      <= pc4_d;
            wb_sel_q   <= wb_sel_d;
            rd_wren_q  <= rd_wren_d;
            inst_q     <= inst_d;
        end
    end

    assign o_dmem_req         = req_c;
    assign o_dmem_we          = req_c & i_mem_lsu_wren;
    assign o_dmem_addr        = {i_mem_alu_data[31:2], 2'b00};
    assign o_dmem_wdata       = lane_wdata;
    assign o_dmem_bmask       = lane_mask;
    assign o_mem_stall        = stall_c;
    assign o_mem_flush        = flush_c;
    assign o_mem_pc_target    = {i_mem_alu_data[31:1], 1'b0};
    assign o_mem_misaligned   = misaligned_c;
    assign o_mem_bus_err      = bus_err_c;
    assign o_mem_fwd_alu_data = i_mem_alu_data;
    assign o_mem_alu_data_wb  = alu_data_q;
    assign o_mem_ld_data_wb   = ld_data_q;
    assign o_mem_pc4_wb       = pc4_q;
    assign o_mem_wb_sel_wb    = wb_sel_q;
    assign o_mem_rd_wren_wb   = rd_wren_q;
    assign o_mem_inst_wb      = inst_q;

endmodule

// File: tb/tb_memory_cycle.sv
// Directed bench for memory_cycle: stores, stalled loads, misalignment,
// branch resolution, wait timeout and reset during a pending access.
module tb_memory_cycle;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc, inst, alu, rs2, rdata;
    logic        br_eq, br_lt, lsu_wren, rd_wren, ready;
    logic [2:0]  slt;
    logic [1:0]  wb_sel;

    logic        dmem_req, dmem_we, stall, flush, misal, bus_err, rd_wren_wb;
    logic [31:0] dmem_addr, dmem_wdata, pc_target, fwd_alu;
    logic [31:0] alu_wb, ld_wb, pc4_wb, inst_wb;
    logic [3:0]  bmask;
    logic [1:0]  wb_sel_wb;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    memory_cycle #(.MAX_WAIT(15)) dut (
        .i_mem_clk          (clk),
        .i_mem_reset        (rst),
        .i_mem_pc           (pc),
        .i_mem_inst         (inst),
        .i_mem_alu_data     (alu),
        .i_mem_rs2_data     (rs2),
        .i_mem_br_equal     (br_eq),
        .i_mem_br_less      (br_lt),
        .i_mem_lsu_wren     (lsu_wren),
        .i_mem_slt_sl       (slt),
        .i_mem_wb_sel       (wb_sel),
        .i_mem_rd_wren      (rd_wren),
        .i_dmem_ready       (ready),
        .i_dmem_rdata       (rdata),
        .o_dmem_req         (dmem_req),
        .o_dmem_we          (dmem_we),
        .o_dmem_addr        (dmem_addr),
        .o_dmem_wdata       (dmem_wdata),
        .o_dmem_bmask       (bmask),
        .o_mem_stall        (stall),
        .o_mem_flush        (flush),
        .o_mem_pc_target    (pc_target),
        .o_mem_misaligned   (misal),
        .o_mem_bus_err      (bus_err),
        .o_mem_fwd_alu_data (fwd_alu),
        .o_mem_alu_data_wb  (alu_wb),
        .o_mem_ld_data_wb   (ld_wb),
        .o_mem_pc4_wb       (pc4_wb),
        .o_mem_wb_sel_wb    (wb_sel_wb),
        .o_mem_rd_wren_wb   (rd_wren_wb),
        .o_mem_inst_wb      (inst_wb)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pc = 32'h0; inst = 32'h0000_0013; alu = 32'h0; rs2 = 32'h0; rdata = 32'h0;
        br_eq = 1'b0; br_lt = 1'b0; lsu_wren = 1'b0; rd_wren = 1'b0; ready = 1'b0;
        slt = 3'b010; wb_sel = 2'b00;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        chk("rst_req",     32'(dmem_req),   32'd0);
        chk("rst_stall",   32'(stall),      32'd0);
        chk("rst_flush",   32'(flush),      32'd0);
        chk("rst_rdwren",  32'(rd_wren_wb), 32'd0);
        chk("rst_pc4",     pc4_wb,          32'd0);
        chk("rst_inst",    inst_wb,         32'd0);
        rst = 1'b0;
        tick();

        // SW 0x100, ready in the same cycle
        pc = 32'h1000; inst = 32'h0000_2023; alu = 32'h100; rs2 = 32'hDEAD_BEEF;
        lsu_wren = 1'b1; slt = 3'b010; wb_sel = 2'b00; rd_wren = 1'b0; ready = 1'b1;
        #1;
        chk("sw_req",   32'(dmem_req), 32'd1);
        chk("sw_we",    32'(dmem_we),  32'd1);
        chk("sw_addr",  dmem_addr,     32'h100);
        chk("sw_bmask", 32'(bmask),    32'hF);
        chk("sw_wdata", dmem_wdata,    32'hDEAD_BEEF);
        chk("sw_stall", 32'(stall),    32'd0);
        tick();
        chk("sw_rdwren_wb", 32'(rd_wren_wb), 32'd0);
        chk("sw_inst_wb",   inst_wb,         32'h0000_2023);
        chk("sw_pc4_wb",    pc4_wb,          32'h1004);

        // ADDI: non-access instruction writes back directly
        idle_inputs();
        inst = 32'h0050_0093; alu = 32'h55; rd_wren = 1'b1;
        #1;
        chk("addi_req", 32'(dmem_req), 32'd0);
        chk("addi_fwd", fwd_alu,       32'h55);
        tick();
        chk("addi_rdwren_wb", 32'(rd_wren_wb), 32'd1);
        chk("addi_alu_wb",    alu_wb,          32'h55);

        // LB 0x203, three wait cycles then ready
        idle_inputs();
        inst = 32'h0001_8083; alu = 32'h203; wb_sel = 2'b01; slt = 3'b000;
        rd_wren = 1'b1; rdata = 32'h80FF_FF00;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("lb_stall", 32'(stall),    32'd1);
            chk("lb_req",   32'(dmem_req), 32'd1);
            chk("lb_addr",  dmem_addr,     32'h200);
            tick();
            chk("lb_bubble_rdwren", 32'(rd_wren_wb), 32'd0);
            chk("lb_bubble_inst",   inst_wb,         32'd0);
        end
        ready = 1'b1;
        #1;
        chk("lb_done_stall", 32'(stall),    32'd0);
        chk("lb_done_req",   32'(dmem_req), 32'd1);
        tick();
        chk("lb_ld_wb",     ld_wb,           32'hFFFF_FF80);
        chk("lb_rdwren_wb", 32'(rd_wren_wb), 32'd1);
        chk("lb_wbsel_wb",  32'(wb_sel_wb),  32'd1);
        chk("lb_inst_wb",   inst_wb,         32'h0001_8083);

        // LHU 0x101: misaligned, no request
        idle_inputs();
        inst = 32'h0001_5083; alu = 32'h101; wb_sel = 2'b01; slt = 3'b101; rd_wren = 1'b1;
        #1;
        chk("lhu_req",   32'(dmem_req), 32'd0);
        chk("lhu_misal", 32'(misal),    32'd1);
        chk("lhu_stall", 32'(stall),    32'd0);
        tick();
        chk("lhu_rdwren_wb", 32'(rd_wren_wb), 32'd0);
        idle_inputs();
        #1;
        chk("lhu_misal_end", 32'(misal), 32'd0);

        // SH 0x102 and SB 0x101 lane placement
        inst = 32'h0000_1023; alu = 32'h102; rs2 = 32'h0000_1234; lsu_wren = 1'b1;
        slt = 3'b001; ready = 1'b1;
        #1;
        chk("sh_bmask", 32'(bmask), 32'hC);
        chk("sh_wdata", dmem_wdata, 32'h1234_1234);
        chk("sh_addr",  dmem_addr,  32'h100);
        alu = 32'h101; rs2 = 32'h0000_00AB; slt = 3'b000;
        #1;
        chk("sb_bmask", 32'(bmask), 32'h2);
        chk("sb_wdata", dmem_wdata, 32'hABAB_ABAB);
        tick();

        // BNE taken, BLT not taken, JAL taken with its own writeback
        idle_inputs();
        inst = 32'h0000_1063; alu = 32'h43;
        #1;
        chk("bne_flush",  32'(flush), 32'd1);
        chk("bne_target", pc_target,  32'h42);
        inst = 32'h0000_4063;
        #1;
        chk("blt_flush", 32'(flush), 32'd0);
        br_lt = 1'b1;
        #1;
        chk("blt_taken_flush", 32'(flush), 32'd1);
        br_lt = 1'b0;
        inst = 32'h0000_00EF; alu = 32'h81; pc = 32'h2000; wb_sel = 2'b10; rd_wren = 1'b1;
        #1;
        chk("jal_flush",  32'(flush), 32'd1);
        chk("jal_target", pc_target,  32'h80);
        tick();
        chk("jal_pc4_wb",    pc4_wb,          32'h2004);
        chk("jal_rdwren_wb", 32'(rd_wren_wb), 32'd1);
        chk("jal_wbsel_wb",  32'(wb_sel_wb),  32'd2);

        // LW 0x300 with ready never asserted: timeout abort
        idle_inputs();
        inst = 32'h0000_2083; alu = 32'h300; wb_sel = 2'b01; slt = 3'b010; rd_wren = 1'b1;
        #1;
        chk("to_stall_idle", 32'(stall), 32'd1);
        for (int i = 1; i <= 14; i++) begin
            tick();
            chk("to_stall_wait", 32'(stall),   32'd1);
            chk("to_no_err",     32'(bus_err), 32'd0);
        end
        tick();
        chk("to_bus_err", 32'(bus_err),  32'd1);
        chk("to_stall",   32'(stall),    32'd0);
        chk("to_req",     32'(dmem_req), 32'd0);
        tick();
        chk("to_bubble_rdwren", 32'(rd_wren_wb), 32'd0);
        chk("to_bubble_inst",   inst_wb,         32'd0);
        chk("to_bubble_wbsel",  32'(wb_sel_wb),  32'd0);
        idle_inputs();
        #1;
        chk("to_err_end", 32'(bus_err), 32'd0);
        tick();

        // Reset while waiting
        inst = 32'h0000_2083; alu = 32'h400; wb_sel = 2'b01; slt = 3'b010; rd_wren = 1'b1;
        pc = 32'h3000;
        tick();
        chk("rw_stall_before", 32'(stall), 32'd1);
        rst = 1'b1;
        tick();
        chk("rw_req",    32'(dmem_req),   32'd0);
        chk("rw_stall",  32'(stall),      32'd0);
        chk("rw_rdwren", 32'(rd_wren_wb), 32'd0);
        chk("rw_pc4",    pc4_wb,          32'd0);
        chk("rw_alu",    alu_wb,          32'd0);
        chk("rw_inst",   inst_wb,         32'd0);
        rst = 1'b0;
        idle_inputs();
        tick();
        chk("rw_after_stall", 32'(stall), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/memory_cycle.md
Name: memory_cycle

Overview:
- MEM pipeline stage, directly downstream of the execute stage.
- Resolves branches and jumps, driving flush and target back to fetch and decode.
- Performs loads and stores over a ready-handshaked data-memory port, with byte/half/word alignment and extension.
- Holds the MEM/WB pipeline register feeding writeback, and stalls upstream while a memory access is pending.

Parameters:
- MAX_WAIT, 15: maximum number of wait cycles on the data-memory port before the access is aborted with a bus error.

Ports:
- i_mem_clk  in  1  clock.
- i_mem_reset  in  1  synchronous, active-high reset.
- i_mem_pc  in  32  PC from EX/MEM.
- i_mem_inst  in  32  instruction from EX/MEM.
- i_mem_alu_data  in  32  ALU result: effective address, or branch/jump target.
- i_mem_rs2_data  in  32  forwarded store data.
- i_mem_br_equal  in  1  registered branch-compare result: equal.
- i_mem_br_less  in  1  registered branch-compare result: less.
- i_mem_lsu_wren  in  1  1 = store.
- i_mem_slt_sl  in  3  access type: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- i_mem_wb_sel  in  2  00 ALU, 01 load, 10 PC+4.
- i_mem_rd_wren  in  1  register-file write enable.
- i_dmem_ready  in  1  memory accepts or completes the current request this cycle.
- i_dmem_rdata  in  32  read word, valid when i_dmem_ready=1.
- o_dmem_req  out  1  request valid.
- o_dmem_we  out  1  1 = write.
- o_dmem_addr  out  32  word address (bits 1:0 = 0).
- o_dmem_wdata  out  32  lane-shifted store data.
- o_dmem_bmask  out  4  byte enables.
- o_mem_stall  out  1  hold PC, IF/ID, ID/EX and EX/MEM.
- o_mem_flush  out  1  branch/jump taken; flush younger stages.
- o_mem_pc_target  out  32  redirect PC.
- o_mem_misaligned  out  1  one-cycle pulse on a misaligned access.
- o_mem_bus_err  out  1  one-cycle pulse on a timeout abort.
- o_mem_fwd_alu_data  out  32  i_mem_alu_data, combinational, for EX forwarding.
- o_mem_alu_data_wb  out  32  registered ALU result.
- o_mem_ld_data_wb  out  32  registered extended load data.
- o_mem_pc4_wb  out  32  registered i_mem_pc+4.
- o_mem_wb_sel_wb  out  2  registered wb_sel.
- o_mem_rd_wren_wb  out  1  registered rd_wren.
- o_mem_inst_wb  out  32  registered instruction.

Behaviour:
- Reset: all registered outputs 0, FSM to IDLE, wait counter 0. o_dmem_req=0. o_mem_stall, o_mem_flush, o_mem_misaligned and o_mem_bus_err are 0.
- Reset mid-access drops o_dmem_req in the following cycle; no writeback occurs.
- Access detection: access = i_mem_lsu_wren OR (i_mem_wb_sel==01). addr = i_mem_alu_data. off = addr[1:0].
- Misaligned when: H/HU with off[0]=1, or W with off!=0.
  - No request is issued; o_mem_misaligned pulses.
  - The MEM/WB entry is written with rd_wren=0; no stall.
- Store lanes:
  - B: bmask = 1<<off, wdata = {4{rs2[7:0]}}.
  - H: bmask = 0011<<off, wdata = {2{rs2[15:0]}}.
  - W: bmask = 1111, wdata = rs2.
- Load data: the byte or half selected by off; sign-extended for B/H, zero-extended for BU/HU.
- FSM, IDLE:
  - Aligned access: o_dmem_req=1, combinationally from the inputs.
  - If i_dmem_ready=1: the access completes this cycle, the MEM/WB register loads, no stall.
  - Else: go to WAIT, o_mem_stall=1, counter=1.
- FSM, WAIT:
  - req, we, addr, wdata and bmask are held stable, driven from the held EX/MEM inputs.
  - o_mem_stall=1 until the completion cycle; in that cycle stall=0, the MEM/WB register loads, and the FSM returns to IDLE.
  - While stalled, the MEM/WB register loads a bubble (rd_wren=0, wb_sel=00, inst=0).
  - If counter==MAX_WAIT with no ready: drop req, pulse o_mem_bus_err, write a bubble, stall=0, return to IDLE. Otherwise counter increments.
- Branch resolution (combinational, inactive during a stall):
  - opcode 1101111 or 1100111: taken.
  - opcode 1100011, by funct3:
    - 000: eq
    - 001: !eq
    - 100/110: less
    - 101/111: !less
  - Taken: o_mem_flush=1, o_mem_pc_target = {alu_data[31:1],1'b0}.
- A flush does not cancel this stage's own writeback.
- Non-access instructions load the MEM/WB register every cycle.
- Store completion writes rd_wren as given (normally 0).

Test Plan:
- SW, addr 0x100, rs2 0xDEADBEEF, ready=1 in the same cycle -> req=1, we=1, addr 0x100, bmask 1111, no stall; next cycle rd_wren_wb=0.
- LB, addr 0x203, rdata 0x80FF_FF00, ready held low 3 cycles -> stall high exactly 3 cycles, addr 0x200 stable throughout; ld_data_wb = 0xFFFFFF80.
- LHU at 0x101 -> no req, misaligned pulse for 1 cycle, rd_wren_wb=0. SH at 0x102, rs2 0x1234 -> bmask 1100, wdata 0x12341234.
- BNE with br_equal=0, alu_data 0x0000_0043 -> flush=1, target 0x42. BLT with br_less=0 -> flush=0.
- ready never asserted -> bus_err pulses after 15 wait cycles, stall drops, a bubble is written to MEM/WB.
- Reset asserted in WAIT -> next cycle req=0, stall=0, all WB outputs 0.
